// File: rtl/cs_cfg_pkg.sv
// Shared register map, unlock key values and unlock FSM state type for cs_config_ctrl.
// Pure declarations: no latency, no flow control.
package cs_cfg_pkg;

    localparam int NUM_CH = 4;

    localparam logic [4:0] ADDR_ENABLE   = 5'h10;
    localparam logic [4:0] ADDR_KEY      = 5'h11;
    localparam logic [4:0] ADDR_COMMIT   = 5'h12;
    localparam logic [4:0] ADDR_STATUS   = 5'h13;
    localparam logic [4:0] ADDR_CONFLICT = 5'h14;

    localparam logic [7:0] KEY_FIRST  = 8'hA5;
    localparam logic [7:0] KEY_SECOND = 8'h5A;

    typedef enum logic [1:0] {
        ST_LOCKED,
        ST_KEY1,
        ST_UNLOCKED,
        ST_COMMIT_WAIT
    } lock_state_e;

    // One-hot of the lowest set bit; lower channel index wins arbitration.
    function automatic logic [NUM_CH-1:0] lowest_hit(input logic [NUM_CH-1:0] hit);
        logic [NUM_CH-1:0] neg;
        neg = ~hit + {{(NUM_CH-1){1'b0}}, 1'b1};
        return hit & neg;
    endfunction

endpackage

// File: rtl/cs_conflict_counter.sv
// Flags multi-channel decoder overlap during PHI2 high and counts it at PHI2 fall.
// Count updates one clk after the falling PHI2 sample; saturates at 8'hFF; clear beats increment.
module cs_conflict_counter (
    input  logic       clk,
    input  logic       rstN,
    input  logic       phi2,
    input  logic [3:0] hit,
    input  logic       clr,
    output logic       flag,
    output logic [7:0] count
);

    logic       phi2_q, phi2_d;
    logic       flag_q, flag_d;
    logic [7:0] count_q, count_d;
    logic       multi_hit;
    logic       phi2_fall;

    always_comb begin
        multi_hit = (hit & (hit - 4'd1)) != 4'd0;
        phi2_fall = phi2_q & ~phi2;
        phi2_d    = phi2;
        flag_d    = flag_q;
        count_d   = count_q;

        if (phi2_fall) begin
            flag_d = 1'b0;
            if (flag_q && (count_q != 8'hFF)) begin
                count_d = count_q + 8'd1;
            end
        end else if (phi2 && multi_hit) begin
            flag_d = 1'b1;
        end

        if (clr) begin
            count_d = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            phi2_q  <= 1'b0;
            flag_q  <= 1'b0;
            count_q <= 8'h00;
        end else begin
            phi2_q  <= phi2_d;
            flag_q  <= flag_d;
            count_q <= count_d;
        end
    end

    assign flag  = flag_q;
    assign count = count_q;

endmodule

// File: rtl/cs_config_ctrl.sv
// Key-protected chip-select config: shadow regs committed to active set on a PHI2-low edge, plus CE arbitration.
// Reads and ceN are combinational; writes take effect next clk; no backpressure (writes outside the FSM window are dropped).
module cs_config_ctrl
    import cs_cfg_pkg::*;
#(
    parameter logic [15:0] CH0_MASK = 16'hE000,
    parameter logic [15:0] CH0_PAT  = 16'hE000,
    parameter logic [3:0]  EN_RST   = 4'b0001
) (
    input  logic        clk,
    input  logic        rstN,
    input  logic        PHI2,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic [4:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic [63:0] cfg_mask,
    output logic [63:0] cfg_pat,
    input  logic [3:0]  dec_ceN,
    output logic [3:0]  ceN,
    output logic        locked
);

    // Shadow byte 4n..4n+3 = mask lo, mask hi, pat lo, pat hi of channel n.
    localparam logic [127:0] SHADOW_RST = {96'd0, CH0_PAT, CH0_MASK};

    lock_state_e   state_q, state_d;
    logic [127:0]  shadow_q, shadow_d;
    logic [3:0]    en_sh_q, en_sh_d;
    logic [63:0]   act_mask_q, act_mask_d;
    logic [63:0]   act_pat_q, act_pat_d;
    logic [3:0]    act_en_q, act_en_d;

    logic          wr_key;
    logic          conflict_clr;
    logic          conflict_flag;
    logic [7:0]    conflict_count;
    logic [3:0]    ce_hit;

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        en_sh_d    = en_sh_q;
        act_mask_d = act_mask_q;
        act_pat_d  = act_pat_q;
        act_en_d   = act_en_q;
        wr_key     = wr_en && (wr_addr == ADDR_KEY);

        case (state_q)
            ST_LOCKED: begin
                if (wr_key && (wr_data == KEY_FIRST)) begin
                    state_d = ST_KEY1;
                end
            end
            ST_KEY1: begin
                // Anything but the second key byte aborts the sequence.
                if (wr_en) begin
                    state_d = (wr_key && (wr_data == KEY_SECOND)) ? ST_UNLOCKED : ST_LOCKED;
                end
            end
            ST_UNLOCKED: begin
                if (wr_en) begin
                    if (!wr_addr[4]) begin
                        shadow_d[{wr_addr[3:0], 3'b000} +: 8] = wr_data;
                    end else if (wr_addr == ADDR_ENABLE) begin
                        en_sh_d = wr_data[3:0];
                    end else if (wr_addr == ADDR_KEY) begin
                        state_d = ST_LOCKED;
                    end else if ((wr_addr == ADDR_COMMIT) && wr_data[0]) begin
                        state_d = ST_COMMIT_WAIT;
                    end
                end
            end
            ST_COMMIT_WAIT: begin
                // Active set only moves while PHI2 is low so a bus cycle never sees a half-updated map.
                if (!PHI2) begin
                    for (int n = 0; n < NUM_CH; n++) begin
                        act_mask_d[16*n +: 16] = shadow_q[32*n +: 16];
                        act_pat_d[16*n +: 16]  = shadow_q[32*n+16 +: 16];
                    end
                    act_en_d = en_sh_q;
                    state_d  = ST_LOCKED;
                end
            end
            default: state_d = ST_LOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= ST_LOCKED;
            shadow_q   <= SHADOW_RST;
            en_sh_q    <= EN_RST;
            act_mask_q <= {48'd0, CH0_MASK};
            act_pat_q  <= {48'd0, CH0_PAT};
            act_en_q   <= EN_RST;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            en_sh_q    <= en_sh_d;
            act_mask_q <= act_mask_d;
            act_pat_q  <= act_pat_d;
            act_en_q   <= act_en_d;
        end
    end

    assign conflict_clr = wr_en && (wr_addr == ADDR_CONFLICT);
    assign ce_hit       = act_en_q & ~dec_ceN;

    cs_conflict_counter u_conflict (
        .clk   (clk),
        .rstN  (rstN),
        .phi2  (PHI2),
        .hit   (ce_hit),
        .clr   (conflict_clr),
        .flag  (conflict_flag),
        .count (conflict_count)
    );

    assign ceN      = ~lowest_hit(ce_hit);
    assign cfg_mask = act_mask_q;
    assign cfg_pat  = act_pat_q;
    assign locked   = (state_q != ST_UNLOCKED);

    always_comb begin
        rd_data = 8'h00;
        if (!rd_addr[4]) begin
            rd_data = shadow_q[{rd_addr[3:0], 3'b000} +: 8];
        end else begin
            case (rd_addr)
                ADDR_ENABLE:   rd_data = {4'b0000, en_sh_q};
                ADDR_STATUS:   rd_data = {5'b00000, conflict_flag,
                                          (state_q == ST_COMMIT_WAIT), locked};
                ADDR_CONFLICT: rd_data = conflict_count;
                default:       rd_data = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_cs_config_ctrl.sv
// Directed bench for cs_config_ctrl: arbitration vector table plus unlock/commit/conflict sequences.
module tb_cs_config_ctrl;

    logic        clk;
    logic        rstN;
    logic        PHI2;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [63:0] cfg_mask;
    logic [63:0] cfg_pat;
    logic [3:0]  dec_ceN;
    logic [3:0]  ceN;
    logic        locked;

    int checks;
    int failures;

    typedef struct {
        logic [3:0] dec;
        logic [3:0] exp_ce;
    } ce_vec_t;

    ce_vec_t vecs[8];

    cs_config_ctrl dut (
        .clk      (clk),
        .rstN     (rstN),
        .PHI2     (PHI2),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .cfg_mask (cfg_mask),
        .cfg_pat  (cfg_pat),
        .dec_ceN  (dec_ceN),
        .ceN      (ceN),
        .locked   (locked)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        chk(nm, {8'h00, rd_data}, {8'h00, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic unlock();
        wr(5'h11, 8'hA5);
        wr(5'h11, 8'h5A);
    endtask

    task automatic conflict_pulse();
        PHI2    = 1'b1;
        dec_ceN = 4'b1100;
        step();
        PHI2    = 1'b0;
        step();
        dec_ceN = 4'b1111;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstN     = 1'b0;
        PHI2     = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = 5'h00;
        wr_data  = 8'h00;
        rd_addr  = 5'h00;
        dec_ceN  = 4'b1111;

        vecs[0] = '{dec: 4'b1111, exp_ce: 4'b1111};
        vecs[1] = '{dec: 4'b1110, exp_ce: 4'b1110};
        vecs[2] = '{dec: 4'b1101, exp_ce: 4'b1101};
        vecs[3] = '{dec: 4'b1100, exp_ce: 4'b1110};
        vecs[4] = '{dec: 4'b1011, exp_ce: 4'b1111};
        vecs[5] = '{dec: 4'b0000, exp_ce: 4'b1110};
        vecs[6] = '{dec: 4'b0111, exp_ce: 4'b1111};
        vecs[7] = '{dec: 4'b1001, exp_ce: 4'b1101};

        #230;
        rstN = 1'b1;
        step();

        // Reset state
        chk("rst_mask0", cfg_mask[15:0], 16'hE000);
        chk("rst_pat0", cfg_pat[15:0], 16'hE000);
        chk("rst_mask_hi", cfg_mask[63:48] | cfg_mask[47:32] | cfg_mask[31:16], 16'h0000);
        chk("rst_locked", {15'd0, locked}, 16'd1);
        rd_chk("rst_enable", 5'h10, 8'h01);
        rd_chk("rst_sh01", 5'h01, 8'hE0);
        rd_chk("rst_sh03", 5'h03, 8'hE0);
        rd_chk("rst_status", 5'h13, 8'h01);
        rd_chk("rst_conflict", 5'h14, 8'h00);
        rd_chk("rst_key_rd", 5'h11, 8'h00);
        dec_ceN = 4'b0000;
        #1;
        chk("rst_ce_all", {12'd0, ceN}, 16'h000E);
        dec_ceN = 4'b1111;

        // Broken key sequence: intervening write aborts, then 5A alone does nothing
        wr(5'h11, 8'hA5);
        wr(5'h00, 8'h12);
        wr(5'h11, 8'h5A);
        chk("brk_locked", {15'd0, locked}, 16'd1);
        rd_chk("brk_sh00", 5'h00, 8'h00);

        // Unlock, COMMIT with bit0 clear is a no-op, any KEY write relocks
        unlock();
        chk("unl_locked", {15'd0, locked}, 16'd0);
        rd_chk("unl_status", 5'h13, 8'h00);
        wr(5'h12, 8'hFE);
        chk("commit0_locked", {15'd0, locked}, 16'd0);
        wr(5'h11, 8'h33);
        chk("key_relock", {15'd0, locked}, 16'd1);

        // Commit held off while PHI2 high, then lands on first PHI2-low edge
        unlock();
        wr(5'h04, 8'h00);
        wr(5'h05, 8'hC0);
        rd_chk("sh05", 5'h05, 8'hC0);
        PHI2 = 1'b1;
        wr(5'h12, 8'h01);
        step();
        step();
        step();
        chk("cw_mask1_held", cfg_mask[31:16], 16'h0000);
        chk("cw_locked", {15'd0, locked}, 16'd1);
        rd_chk("cw_status", 5'h13, 8'h03);
        wr(5'h04, 8'h55);
        rd_chk("cw_wr_ignored", 5'h04, 8'h00);
        PHI2 = 1'b0;
        step();
        chk("cm_mask1", cfg_mask[31:16], 16'hC000);
        chk("cm_mask0", cfg_mask[15:0], 16'hE000);
        chk("cm_locked", {15'd0, locked}, 16'd1);
        rd_chk("cm_status", 5'h13, 8'h01);

        // Enable channels 0 and 1, commit with PHI2 already low
        unlock();
        wr(5'h10, 8'h03);
        wr(5'h12, 8'h01);
        step();
        rd_chk("en_shadow", 5'h10, 8'h03);
        chk("en_locked", {15'd0, locked}, 16'd1);

        for (int i = 0; i < 8; i++) begin
            dec_ceN = vecs[i].dec;
            #1;
            chk($sformatf("ce_vec%0d", i), {12'd0, ceN}, {12'd0, vecs[i].exp_ce});
        end
        dec_ceN = 4'b1111;

        // Overlap while PHI2 high sets the flag; falling PHI2 counts it
        PHI2    = 1'b1;
        dec_ceN = 4'b1100;
        #1;
        chk("ovl_ce", {12'd0, ceN}, 16'h000E);
        step();
        rd_chk("ovl_flag", 5'h13, 8'h05);
        PHI2 = 1'b0;
        step();
        dec_ceN = 4'b1111;
        rd_chk("ovl_count1", 5'h14, 8'h01);
        rd_chk("ovl_flag_clr", 5'h13, 8'h01);

        // Saturation, then clear coinciding with an increment edge
        for (int i = 0; i < 254; i++) begin
            conflict_pulse();
        end
        rd_chk("sat_ff", 5'h14, 8'hFF);
        conflict_pulse();
        rd_chk("sat_hold", 5'h14, 8'hFF);
        PHI2    = 1'b1;
        dec_ceN = 4'b1100;
        step();
        PHI2    = 1'b0;
        dec_ceN = 4'b1111;
        wr(5'h14, 8'h77);
        rd_chk("clr_wins", 5'h14, 8'h00);
        chk("clr_locked", {15'd0, locked}, 16'd1);

        // Reset while a commit is pending abandons it
        unlock();
        wr(5'h00, 8'h34);
        PHI2 = 1'b1;
        wr(5'h12, 8'h01);
        rd_chk("pre_rst_status", 5'h13, 8'h03);
        rstN = 1'b0;
        #2;
        rstN = 1'b1;
        #1;
        PHI2 = 1'b0;
        step();
        chk("ar_mask0", cfg_mask[15:0], 16'hE000);
        chk("ar_mask1", cfg_mask[31:16], 16'h0000);
        chk("ar_locked", {15'd0, locked}, 16'd1);
        rd_chk("ar_sh00", 5'h00, 8'h00);
        rd_chk("ar_sh05", 5'h05, 8'h00);
        rd_chk("ar_enable", 5'h10, 8'h01);
        dec_ceN = 4'b1101;
        #1;
        chk("ar_ce", {12'd0, ceN}, 16'h000F);
        dec_ceN = 4'b1111;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cs_config_ctrl.md
CS_CONFIG_CTRL -- requirements
Module: cs_config_ctrl

Interface
REQ-001 Parameter CH0_MASK, default 16'hE000: active channel-0 mask after reset.
REQ-002 Parameter CH0_PAT, default 16'hE000: active channel-0 pattern after reset; channels 1-3 reset to mask 0, pattern 0.
REQ-003 Parameter EN_RST, default 4'b0001: active channel-enable bits after reset.
REQ-004 clk  in  1  system clock; all state on rising edge.
REQ-005 rstN  in  1  asynchronous, active-low reset.
REQ-006 PHI2  in  1  CPU bus phase, synchronous to clk.
REQ-007 wr_en  in  1  single-cycle register write strobe.
REQ-008 wr_addr  in  5  write register address.
REQ-009 wr_data  in  8  write data.
REQ-010 rd_addr  in  5  read register address.
REQ-011 rd_data  out  8  combinational read data.
REQ-012 cfg_mask  out  64  active masks, channel n at [16n+15:16n].
REQ-013 cfg_pat  out  64  active patterns, same packing.
REQ-014 dec_ceN  in  4  active-low match from the four per-channel address decoders.
REQ-015 ceN  out  4  arbitrated active-low chip enables, at most one low.
REQ-016 locked  out  1  high when configuration writes are blocked.

Function
REQ-017 Register map: 0x00-0x0F shadow, channel n at 4n: mask lo, mask hi, pattern lo, pattern hi; 0x10 ENABLE (shadow bits 3:0); 0x11 KEY; 0x12 COMMIT; 0x13 STATUS; 0x14 CONFLICT.
REQ-018 Unlock FSM states LOCKED, KEY1, UNLOCKED, COMMIT_WAIT; reset state LOCKED.
REQ-019 LOCKED: KEY write 8'hA5 -> KEY1; all other writes ignored.
REQ-020 KEY1: KEY write 8'h5A -> UNLOCKED; any other write (any address, any value) -> LOCKED, write discarded.
REQ-021 UNLOCKED: writes to 0x00-0x10 update shadow; KEY write (any value) -> LOCKED; COMMIT write with bit0=1 -> COMMIT_WAIT.
REQ-022 COMMIT_WAIT: on first clk edge with PHI2 low (may be the edge following the COMMIT write), copy all shadow regs and ENABLE to active, go to LOCKED; writes during COMMIT_WAIT ignored.
REQ-023 Active config never changes while PHI2 high.
REQ-024 locked = 1 in LOCKED, KEY1, COMMIT_WAIT; 0 in UNLOCKED.
REQ-025 CONFLICT write (any state, any value) clears counter; not key-protected.
REQ-026 ceN[i] low iff dec_ceN[i] low, active enable[i] = 1, and no lower index j satisfies the same; lower index wins.
REQ-027 Conflict flag sets on any clk edge with PHI2 high and two or more enabled channels with dec_ceN low.
REQ-028 On PHI2 falling (registered PHI2 = 1, PHI2 = 0): if flag set, CONFLICT count +1, saturating at 8'hFF; flag clears.
REQ-029 Simultaneous CONFLICT write and increment: clear wins, result 0.
REQ-030 STATUS read: bit0 locked, bit1 = 1 in COMMIT_WAIT, bit2 conflict flag, others 0.
REQ-031 Reads return shadow contents for 0x00-0x10, 0x00 for KEY/COMMIT and unmapped addresses; reads have no side effects.

Reset
REQ-032 rstN low: FSM LOCKED, shadow and active regs to parameter defaults, counter and flag 0, registered PHI2 0, ceN per REQ-026 from reset config.
REQ-033 Reset during COMMIT_WAIT abandons the commit; active regs hold defaults.

Structure
REQ-034 Shared package cs_cfg_pkg holds register addresses, key constants 8'hA5/8'h5A, FSM state type.
REQ-035 One sub-module, cs_conflict_counter: flag, edge detect, saturating counter, clear priority.

Verification
REQ-036 Reset -> cfg_mask[15:0] = 16'hE000, cfg_pat[15:0] = 16'hE000, ENABLE = 4'b0001, locked = 1.
REQ-037 KEY A5, KEY 5A, write 0x04 = 8'h00, 0x05 = 8'hC0, COMMIT 1 with PHI2 high for 3 clks -> active unchanged until first PHI2-low edge, then cfg_mask[31:16] = 16'hC000, locked = 1.
REQ-038 KEY A5, write 0x00, KEY 5A -> stays LOCKED, shadow 0x00 unchanged.
REQ-039 Enable 4'b0011, dec_ceN = 4'b1100 with PHI2 high -> ceN = 4'b1110; after PHI2 falls, CONFLICT = 1.
REQ-040 Counter at 8'hFF plus conflict -> stays 8'hFF; CONFLICT write on increment edge -> 0.
